// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN adds an even-parity bit after each word.
package bit_serializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

`ifdef BIT_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

   // Bits needed to count 0..w inclusive.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Producer-side word handshake plus serial output bundle of the bit serializer.
// Feature macro honoured by the design: BIT_SERIALIZER_PARITY_EN.
interface bit_serializer_if
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_sof;
   logic             busy;

   // Producer / observer side.
   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  sout,
      input  sout_valid,
      input  sout_sof,
      input  busy
   );

   // Serializer side.
   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output sout,
      output sout_valid,
      output sout_sof,
      output busy
   );

endinterface

// File: rtl/bit_serializer_hold.sv
// One-entry holding register between the producer and the shifter.
// Independent of BIT_SERIALIZER_PARITY_EN.
module bit_serializer_hold
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full,
   output logic             full_nxt_c
);

   logic accept_c;

   // Ready is the inverse of the full flag, held low while reset is asserted.
   assign din_ready = rst & ~full;
   assign accept_c  = din_valid & din_ready;

   // Accept and take never coincide: take needs full, accept needs empty.
   assign full_nxt_c = accept_c | (full & ~take);

   // Hold flag and captured word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
         data <= '0;
      end else begin
         full <= full_nxt_c;
         if (accept_c) begin
            data <= din;
         end
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: holding register feeding a WIDTH-bit shifter, one bit per cycle.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit (XOR of the data bits) to each word.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   bit_serializer_if.slave  bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             sv_q, sv_d;
   logic             sof_q, sof_d;
   logic             busy_q, busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             hold_full_nxt;
   logic             take_c;

   bit_serializer_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk        (clk),
      .rst        (rst),
      .din        (bus.din),
      .din_valid  (bus.din_valid),
      .din_ready  (bus.din_ready),
      .take       (take_c),
      .data       (hold_data),
      .full       (hold_full),
      .full_nxt_c (hold_full_nxt)
   );

   // Next state, shifter and next output values; a load presents the first bit on the same edge.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      sout_d  = 1'b0;
      sv_d    = 1'b0;
      sof_d   = 1'b0;
      take_c  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         IDLE: begin
            if (hold_full) begin
               take_c = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(WIDTH)) begin
`ifdef BIT_SERIALIZER_PARITY_EN
               state_d = PAR;
               sout_d  = par_q;
               sv_d    = 1'b1;
`else
               if (hold_full) begin
                  take_c = 1'b1;
               end else begin
                  state_d = IDLE;
               end
`endif
            end else begin
               sv_d  = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (MSB_FIRST != 0) begin
                  sout_d  = shreg_q[WIDTH-1];
                  shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               end else begin
                  sout_d  = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               end
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PAR: begin
            if (hold_full) begin
               take_c = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reload from the holding register: first bit goes out now, the rest stay in the shifter.
      if (take_c) begin
         state_d = SHIFT;
         sv_d    = 1'b1;
         sof_d   = 1'b1;
         cnt_d   = CW'(1);
         if (MSB_FIRST != 0) begin
            sout_d  = hold_data[WIDTH-1];
            shreg_d = {hold_data[WIDTH-2:0], 1'b0};
         end else begin
            sout_d  = hold_data[0];
            shreg_d = {1'b0, hold_data[WIDTH-1:1]};
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         par_d = ^hold_data;
`endif
      end
   end

   // Busy tracks the next state and the next hold flag so the registered copy matches them.
   always_comb begin
      busy_d = (state_d != IDLE) | hold_full_nxt;
   end

   // State, shifter, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         sout_q  <= 1'b0;
         sv_q    <= 1'b0;
         sof_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         sv_q    <= sv_d;
         sof_q   <= sof_d;
         busy_q  <= busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.sout       = sout_q;
   assign bus.sout_valid = sv_q;
   assign bus.sout_sof   = sof_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: one MSB-first and one LSB-first instance.
// Expected parity handling follows BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;
   import bit_serializer_pkg::*;

   localparam int unsigned W  = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int unsigned PB = 1;
`else
   localparam int unsigned PB = 0;
`endif
   localparam int unsigned WL = W + PB;

   typedef struct {
      logic b;
      logic sof;
      int   stamp;
   } obs_t;

   typedef struct {
      logic [W-1:0] d;
      int           stamp;
   } acc_t;

   typedef struct {
      int           sel;
      logic [W-1:0] d;
      logic [W-1:0] exp;
      logic         exp_par;
   } tv_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   bit_serializer_if #(.WIDTH(W)) bus0 ();
   bit_serializer_if #(.WIDTH(W)) bus1 ();

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   idle_bad = 0;
   int   busy_bad = 0;
   obs_t obs0[$];
   obs_t obs1[$];
   acc_t acc0[$];
   acc_t acc1[$];
   tv_t  tv[8];

   always #5 clk = ~clk;

   // Record accepted words with the number of the accepting edge.
   always @(posedge clk) begin
      if (bus0.din_valid && bus0.din_ready) acc0.push_back('{bus0.din, cyc});
      if (bus1.din_valid && bus1.din_ready) acc1.push_back('{bus1.din, cyc});
      cyc = cyc + 1;
   end

   // Collect valid serial bits; flag non-zero idle outputs and valid bits without busy.
   always @(negedge clk) begin
      if (bus0.sout_valid) obs0.push_back('{bus0.sout, bus0.sout_sof, cyc - 1});
      else if (bus0.sout || bus0.sout_sof) idle_bad++;
      if (bus1.sout_valid) obs1.push_back('{bus1.sout, bus1.sout_sof, cyc - 1});
      else if (bus1.sout || bus1.sout_sof) idle_bad++;
      if (bus0.sout_valid && !bus0.busy) busy_bad++;
      if (bus1.sout_valid && !bus1.busy) busy_bad++;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic v, input logic [W-1:0] d);
      if (sel == 0) begin
         bus0.din_valid = v;
         bus0.din       = d;
      end else begin
         bus1.din_valid = v;
         bus1.din       = d;
      end
   endtask

   task automatic clear_q();
      obs0.delete();
      obs1.delete();
      acc0.delete();
      acc1.delete();
   endtask

   // Offer a word and keep it valid until an edge accepts it; returns just after that edge.
   task automatic push(input int sel, input logic [W-1:0] d);
      bit   ok;
      logic r;
      ok = 1'b0;
      tick();
      drive(sel, 1'b1, d);
      for (int i = 0; i < 40; i++) begin
         r = (sel == 0) ? bus0.din_ready : bus1.din_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("push_accepted", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!bus0.busy && !bus0.sout_valid && !bus1.busy && !bus1.sout_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", ok, 1);
   endtask

   // Reference stream: every accepted word, bits in the configured order, parity appended if enabled.
   task automatic check_stream(input int sel, input string nm);
      obs_t         o[$];
      acc_t         a[$];
      logic         eb[$];
      logic         es[$];
      logic [W-1:0] d;
      int           n;
      if (sel == 0) begin
         o = obs0;
         a = acc0;
      end else begin
         o = obs1;
         a = acc1;
      end
      foreach (a[k]) begin
         d = a[k].d;
         for (int i = 0; i < int'(W); i++) begin
            eb.push_back((sel == 0) ? d[int'(W) - 1 - i] : d[i]);
            es.push_back(i == 0);
         end
         if (PB != 0) begin
            eb.push_back(^d);
            es.push_back(1'b0);
         end
      end
      chk({nm, "_bitcount"}, o.size(), eb.size());
      n = (o.size() < eb.size()) ? o.size() : eb.size();
      for (int i = 0; i < n; i++) begin
         chk({nm, "_bit"}, o[i].b, eb[i]);
         chk({nm, "_sof"}, o[i].sof, es[i]);
      end
   endtask

   // First bit one edge after the accept edge (two edges counting the accept), then no gaps.
   task automatic check_timing(input int sel, input string nm);
      obs_t o[$];
      acc_t a[$];
      int   gaps;
      if (sel == 0) begin
         o = obs0;
         a = acc0;
      end else begin
         o = obs1;
         a = acc1;
      end
      gaps = 0;
      if (o.size() == 0 || a.size() == 0) begin
         chk({nm, "_has_data"}, o.size() * a.size(), 1);
      end else begin
         chk({nm, "_latency"}, o[0].stamp - a[0].stamp, 1);
         for (int i = 1; i < o.size(); i++) begin
            if (o[i].stamp != o[i-1].stamp + 1) gaps++;
         end
         chk({nm, "_gaps"}, gaps, 0);
      end
   endtask

   initial begin
      int  nw;
      tv_t t;

      tv[0] = '{0, 8'hDB, 8'b11011011, 1'b0};
      tv[1] = '{1, 8'h0B, 8'b11010000, 1'b1};
      tv[2] = '{0, 8'h01, 8'b00000001, 1'b1};
      tv[3] = '{0, 8'hA5, 8'b10100101, 1'b0};
      tv[4] = '{1, 8'hA5, 8'b10100101, 1'b0};
      tv[5] = '{1, 8'h80, 8'b00000001, 1'b1};
      tv[6] = '{0, 8'hFF, 8'b11111111, 1'b0};
      tv[7] = '{0, 8'h00, 8'b00000000, 1'b0};

      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);

      // Outputs during reset.
      #2;
      chk("rst_sout0", bus0.sout, 0);
      chk("rst_valid0", bus0.sout_valid, 0);
      chk("rst_sof0", bus0.sout_sof, 0);
      chk("rst_busy0", bus0.busy, 0);
      chk("rst_ready0", bus0.din_ready, 0);
      chk("rst_valid1", bus1.sout_valid, 0);
      chk("rst_busy1", bus1.busy, 0);
      chk("rst_ready1", bus1.din_ready, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_ready", bus0.din_ready, 1);

      // Single-word table.
      for (int k = 0; k < 8; k++) begin
         t = tv[k];
         clear_q();
         push(t.sel, t.d);
         tick();
         drive(t.sel, 1'b0, '0);
         wait_idle();
         if (t.sel == 0) begin
            chk("tv_len", obs0.size(), WL);
            for (int i = 0; i < int'(W) && i < obs0.size(); i++) begin
               chk("tv_bit", obs0[i].b, t.exp[int'(W) - 1 - i]);
               chk("tv_sof", obs0[i].sof, i == 0);
            end
            if (PB != 0 && obs0.size() > int'(W)) chk("tv_parity", obs0[W].b, t.exp_par);
         end else begin
            chk("tv_len", obs1.size(), WL);
            for (int i = 0; i < int'(W) && i < obs1.size(); i++) begin
               chk("tv_bit", obs1[i].b, t.exp[int'(W) - 1 - i]);
               chk("tv_sof", obs1[i].sof, i == 0);
            end
            if (PB != 0 && obs1.size() > int'(W)) chk("tv_parity", obs1[W].b, t.exp_par);
         end
         check_timing(t.sel, "tv");
      end

      // Back-to-back words with valid held high: contiguous stream.
      clear_q();
      push(0, 8'hA5);
      push(0, 8'h3C);
      tick();
      drive(0, 1'b0, '0);
      wait_idle();
      chk("b2b_len", obs0.size(), 2 * WL);
      begin
         logic [15:0] pat;
         pat = 16'hA53C;
         for (int j = 0; j < obs0.size() && j < int'(2 * WL); j++) begin
            if ((j % int'(WL)) < int'(W))
               chk("b2b_bit", obs0[j].b, pat[15 - ((j / int'(WL)) * 8 + (j % int'(WL)))]);
         end
      end
      check_stream(0, "b2b");
      check_timing(0, "b2b");

      // Reset after the third bit of 8'hFF while a second word is held.
      clear_q();
      push(0, 8'hFF);
      tick();
      drive(0, 1'b1, 8'h5A);
      for (int i = 0; i < 20 && obs0.size() < 3; i++) tick();
      chk("mid_bits_before_rst", obs0.size(), 3);
      chk("mid_second_accepted", acc0.size(), 2);
      rst = 1'b0;
      #1;
      chk("mid_sout", bus0.sout, 0);
      chk("mid_valid", bus0.sout_valid, 0);
      chk("mid_sof", bus0.sout_sof, 0);
      chk("mid_busy", bus0.busy, 0);
      chk("mid_ready", bus0.din_ready, 0);
      drive(0, 1'b0, '0);
      tick();
      tick();
      clear_q();
      rst = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      chk("mid_no_output", obs0.size(), 0);
      chk("mid_idle_busy", bus0.busy, 0);
      chk("mid_ready_back", bus0.din_ready, 1);
      push(0, 8'hC3);
      tick();
      drive(0, 1'b0, '0);
      wait_idle();
      check_stream(0, "post_mid");
      check_timing(0, "post_mid");

      // Randomized words and gaps against the stream model, both bit orders.
      for (int sel = 0; sel < 2; sel++) begin
         clear_q();
         nw = 40;
         for (int k = 0; k < nw; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
               tick();
               drive(sel, 1'b0, '0);
               for (int g = 1; g < gap; g++) tick();
            end
            push(sel, W'($urandom));
         end
         tick();
         drive(sel, 1'b0, '0);
         wait_idle();
         chk("rand_accepts", (sel == 0) ? acc0.size() : acc1.size(), nw);
         check_stream(sel, "rand");
      end

      chk("idle_outputs_zero", idle_bad, 0);
      chk("busy_while_valid", busy_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
